// File: rtl/display_seq_ctrl.sv
// Display message sequencer: level banner, blank play screen, timed win/lose banner.
// Optional result blink is enabled by defining DISPLAY_BLINK_EN.
module display_seq_ctrl #(
  parameter int NIVEL_CYCLES  = 50_000_000,
  parameter int RESULT_CYCLES = 150_000_000,
  parameter int BLINK_CYCLES  = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] nivel,
  input  logic       venceu,
  input  logic       perdeu,
  output logic [1:0] displayAddr,
  output logic [1:0] modo,
  output logic       ocupado,
  output logic       fim
);

  localparam int MAX_A = (NIVEL_CYCLES > RESULT_CYCLES) ? NIVEL_CYCLES : RESULT_CYCLES;
  localparam int MAX_P = (MAX_A > BLINK_CYCLES) ? MAX_A : BLINK_CYCLES;
  localparam int CW    = (MAX_P > 2) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] NIVEL_LAST  = CW'(NIVEL_CYCLES - 1);
  localparam logic [CW-1:0] RESULT_LAST = CW'(RESULT_CYCLES - 1);

  localparam logic [1:0] ADDR_NIVEL = 2'b00;
  localparam logic [1:0] ADDR_WIN   = 2'b01;
  localparam logic [1:0] ADDR_LOSE  = 2'b10;
  localparam logic [1:0] ADDR_BLANK = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    NIVEL  = 2'b01,
    JOGO   = 2'b10,
    RESULT = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      msg_q, msg_d;
  logic [1:0]      addr_q, addr_d;
  logic [1:0]      modo_q, modo_d;
  logic            ocupado_q, ocupado_d;
  logic            fim_q, fim_d;

`ifdef DISPLAY_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            shown_q, shown_d;
`endif

  // Next-state, hold counter and registered-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    modo_d  = modo_q;
    fim_d   = 1'b0;
`ifdef DISPLAY_BLINK_EN
    bcnt_d  = bcnt_q;
    shown_d = shown_q;
`endif

    case (state_q)
      IDLE: begin
        if (iniciar) begin
          modo_d  = nivel;
          cnt_d   = {CW{1'b0}};
          state_d = NIVEL;
        end else begin
          state_d = IDLE;
        end
      end
      NIVEL, JOGO: begin
        // A game-end event wins over a level timeout in the same cycle; lose beats win
        if (venceu || perdeu) begin
          state_d = RESULT;
          cnt_d   = {CW{1'b0}};
          msg_d   = perdeu ? ADDR_LOSE : ADDR_WIN;
`ifdef DISPLAY_BLINK_EN
          bcnt_d  = {BW{1'b0}};
          shown_d = 1'b1;
`endif
        end else if (state_q == NIVEL) begin
          if (cnt_q == NIVEL_LAST) begin
            cnt_d   = {CW{1'b0}};
            state_d = JOGO;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = JOGO;
        end
      end
      RESULT: begin
        if (cnt_q == RESULT_LAST) begin
          cnt_d   = {CW{1'b0}};
          fim_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`ifdef DISPLAY_BLINK_EN
        if (bcnt_q == BLINK_LAST) begin
          bcnt_d  = {BW{1'b0}};
          shown_d = ~shown_q;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase

    ocupado_d = (state_d != IDLE);
    case (state_d)
      NIVEL:   addr_d = ADDR_NIVEL;
`ifdef DISPLAY_BLINK_EN
      RESULT:  addr_d = shown_d ? msg_d : ADDR_BLANK;
`else
      RESULT:  addr_d = msg_d;
`endif
      default: addr_d = ADDR_BLANK;
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      msg_q     <= 2'b00;
      addr_q    <= ADDR_BLANK;
      modo_q    <= 2'b00;
      ocupado_q <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      msg_q     <= msg_d;
      addr_q    <= addr_d;
      modo_q    <= modo_d;
      ocupado_q <= ocupado_d;
      fim_q     <= fim_d;
    end
  end

`ifdef DISPLAY_BLINK_EN
  // Blink phase registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcnt_q  <= {BW{1'b0}};
      shown_q <= 1'b1;
    end else begin
      bcnt_q  <= bcnt_d;
      shown_q <= shown_d;
    end
  end
`endif

  assign displayAddr = addr_q;
  assign modo        = modo_q;
  assign ocupado     = ocupado_q;
  assign fim         = fim_q;

endmodule

// File: tb/tb_display_seq_ctrl.sv
// Self-checking bench for display_seq_ctrl: directed vector table, corner sequences,
// and randomized traffic against a phase/time-remaining reference model.
module tb_display_seq_ctrl;

  localparam int NC = 4;
  localparam int RC = 8;
  localparam int BC = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [1:0] nivel = 2'b00;
  logic       venceu = 1'b0;
  logic       perdeu = 1'b0;
  logic [1:0] displayAddr;
  logic [1:0] modo;
  logic       ocupado;
  logic       fim;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  display_seq_ctrl #(
    .NIVEL_CYCLES(NC),
    .RESULT_CYCLES(RC),
    .BLINK_CYCLES(BC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .nivel(nivel),
    .venceu(venceu),
    .perdeu(perdeu),
    .displayAddr(displayAddr),
    .modo(modo),
    .ocupado(ocupado),
    .fim(fim)
  );

  // Reference model: which screen is up and how many cycles it still has to run
  int         m_phase;  // 0 idle, 1 level banner, 2 playing, 3 result banner
  int         m_left;
  logic [1:0] m_msg;
  logic [1:0] m_modo;
  logic       m_fim;

  function automatic logic [1:0] res_exp(input logic [1:0] msg, input int idx);
`ifdef DISPLAY_BLINK_EN
    if (((idx / BC) % 2) == 1) return 2'b11;
`endif
    return msg;
  endfunction

  function automatic logic [1:0] model_addr();
    if (m_phase == 1) return 2'b00;
    if (m_phase == 3) return res_exp(m_msg, RC - m_left);
    return 2'b11;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_left  = 0;
    m_msg   = 2'b00;
    m_modo  = 2'b00;
    m_fim   = 1'b0;
  endtask

  task automatic model_step(input logic ini, input logic [1:0] niv, input logic ven, input logic per);
    m_fim = 1'b0;
    if (m_phase == 0) begin
      if (ini) begin
        m_phase = 1;
        m_left  = NC;
        m_modo  = niv;
      end
    end else if (m_phase == 1 || m_phase == 2) begin
      if (ven || per) begin
        m_phase = 3;
        m_left  = RC;
        m_msg   = per ? 2'b10 : 2'b01;
      end else if (m_phase == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 2;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_phase = 0;
        m_fim   = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic ini, input logic [1:0] niv, input logic ven, input logic per);
    iniciar = ini;
    nivel   = niv;
    venceu  = ven;
    perdeu  = per;
    @(posedge clock);
    model_step(ini, niv, ven, per);
    #1;
    chk("model_addr", displayAddr, model_addr());
    chk("model_modo", modo, m_modo);
    chk("model_ocupado", {1'b0, ocupado}, {1'b0, (m_phase != 0)});
    chk("model_fim", {1'b0, fim}, {1'b0, m_fim});
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr"}, displayAddr, 2'b11);
    chk({tag, "_modo"}, modo, 2'b00);
    chk({tag, "_ocupado"}, {1'b0, ocupado}, 2'b00);
    chk({tag, "_fim"}, {1'b0, fim}, 2'b00);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_values(tag);
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    logic       ini;
    logic [1:0] niv;
    logic       ven;
    logic       per;
    logic [1:0] addr;
    logic [1:0] modo;
    logic       ocp;
    logic       fim;
  } vec_t;

  vec_t tbl[18];
  logic [1:0] blink_seq[8];

  initial begin
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b10, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b11, 2'b10, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b11, 2'b10, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'b01, 1'b1, 1'b0, res_exp(2'b01, 0), 2'b10, 1'b1, 1'b0};
    for (int i = 8; i < 15; i++) begin
      tbl[i] = '{logic'(i % 2), 2'b01, logic'(i == 10), logic'(i == 12),
                 res_exp(2'b01, i - 7), 2'b10, 1'b1, 1'b0};
    end
    tbl[15] = '{1'b0, 2'b01, 1'b0, 1'b0, 2'b11, 2'b10, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 2'b01, 1'b0, 1'b0, 2'b11, 2'b10, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 2'b01, 1'b1, 1'b0, 2'b11, 2'b10, 1'b0, 1'b0};

`ifdef DISPLAY_BLINK_EN
    blink_seq = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11};
`else
    blink_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
`endif

    model_reset();
    #1 reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check_reset_values("por");
    @(negedge clock);
    reset = 1'b1;

    // Directed table: start, level hold, ignored inputs in play, win, fim, idle
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].ini, tbl[i].niv, tbl[i].ven, tbl[i].per);
      chk($sformatf("tbl%0d_addr", i), displayAddr, tbl[i].addr);
      chk($sformatf("tbl%0d_modo", i), modo, tbl[i].modo);
      chk($sformatf("tbl%0d_ocupado", i), {1'b0, ocupado}, {1'b0, tbl[i].ocp});
      chk($sformatf("tbl%0d_fim", i), {1'b0, fim}, {1'b0, tbl[i].fim});
    end

    // Both events on the level-timeout cycle: lose shown, then held iniciar restarts from idle
    step(1'b1, 2'b11, 1'b0, 1'b0);
    chk("prio_start_addr", displayAddr, 2'b00);
    chk("prio_start_modo", modo, 2'b11);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("prio_last_nivel", displayAddr, 2'b00);
    step(1'b0, 2'b00, 1'b1, 1'b1);
    chk("prio_res0", displayAddr, blink_seq[0]);
    chk("prio_ocupado", {1'b0, ocupado}, 2'b01);
    for (int i = 1; i < 8; i++) begin
      step(logic'(i >= 5), 2'b01, 1'b1, 1'b0);
      chk($sformatf("prio_res%0d", i), displayAddr, blink_seq[i]);
      chk($sformatf("prio_res%0d_fim", i), {1'b0, fim}, 2'b00);
    end
    step(1'b1, 2'b01, 1'b0, 1'b0);
    chk("prio_fim", {1'b0, fim}, 2'b01);
    chk("prio_idle_addr", displayAddr, 2'b11);
    chk("prio_idle_ocupado", {1'b0, ocupado}, 2'b00);
    chk("prio_idle_modo", modo, 2'b11);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    chk("restart_addr", displayAddr, 2'b00);
    chk("restart_modo", modo, 2'b01);
    chk("restart_fim", {1'b0, fim}, 2'b00);

    // Reset asserted in the middle of a result banner
    step(1'b0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("pre_reset_ocupado", {1'b0, ocupado}, 2'b01);
    do_reset("mid_result_reset");
    step(1'b0, 2'b10, 1'b1, 1'b0);
    chk("post_reset_addr", displayAddr, 2'b11);

    // Randomized traffic against the reference model, with one reset in the middle
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset("rand_reset");
      step(logic'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           logic'($urandom_range(0, 11) == 0), logic'($urandom_range(0, 11) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
